// File: rtl/rc_pulse_pkg.sv
// rc_pulse_pkg: shared constants and helpers for the RC pulse encoder.
//   MIN_US      - pulse width for command 0, in microseconds
//   US_PER_STEP - microseconds added per command step
//   CMD_MAX     - largest meaningful command; larger values saturate
//   sat_cmd()   - clamps a raw command to 0..CMD_MAX
//   width_us()  - converts a saturated command to a pulse width in microseconds
package rc_pulse_pkg;

    localparam int         MIN_US      = 1000;
    localparam int         US_PER_STEP = 4;
    localparam logic [7:0] CMD_MAX     = 8'd250;

    function automatic logic [7:0] sat_cmd(input logic [7:0] c);
        return (c > CMD_MAX) ? CMD_MAX : c;
    endfunction

    // 1000 + 4*250 = 2000 is the largest result, so 11 bits always suffice.
    function automatic logic [10:0] width_us(input logic [7:0] a);
        return 11'(MIN_US) + 11'(US_PER_STEP) * {3'b000, a};
    endfunction

endpackage

// File: rtl/us_prescaler.sv
// us_prescaler: divides clk down to a one-cycle tick once per microsecond.
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   us_tick - high for one cycle when the prescaler is at TICKS_PER_US-1
module us_prescaler #(
    parameter int TICKS_PER_US = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic us_tick
);

    localparam int PRE_W = $clog2(TICKS_PER_US);

    logic [PRE_W-1:0] pre;

    assign us_tick = (pre == PRE_W'(TICKS_PER_US - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (us_tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/rc_pulse_transmitter.sv
// rc_pulse_transmitter: servo-style pulse encoder, one 1000..2000 us pulse
// per frame on pulse_out.
//   clk, rst_n   - system clock, asynchronous active-low reset
//   cmd          - 8-bit channel command (0 -> 1000 us, 250+ -> 2000 us)
//   cmd_valid    - cmd is presented
//   cmd_ready    - pending buffer empty
//   arm          - output enable, sampled at frame boundaries
//   pulse_out    - registered pulse line
//   frame_strobe - one-cycle pulse at the start of each frame's pulse slot
//   stale        - failsafe active, width held at 1000 us
//
// Handshake: a command transfers on any rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready does not depend on cmd_valid, and a
// presented command may be held for any number of cycles until it transfers.
module rc_pulse_transmitter
    import rc_pulse_pkg::*;
#(
    parameter int TICKS_PER_US   = 50,
    parameter int FRAME_US       = 2500,
    parameter int TIMEOUT_FRAMES = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       arm,
    output logic       pulse_out,
    output logic       frame_strobe,
    output logic       stale
);

    localparam int CNT_W  = $clog2(FRAME_US);
    localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);

    logic              us_tick;
    logic              fb;
    logic              accept;
    logic [CNT_W-1:0]  us_cnt;
    logic [CNT_W-1:0]  us_cnt_nxt;
    logic [7:0]        pend;
    logic              pend_full;
    logic [7:0]        active;
    logic [7:0]        active_nxt;
    logic [MISS_W-1:0] miss_cnt;
    logic [MISS_W-1:0] miss_nxt;
    logic              stale_nxt;
    logic              arm_f;
    logic              arm_f_nxt;
    logic              pulse_nxt;

    us_prescaler #(
        .TICKS_PER_US(TICKS_PER_US)
    ) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .us_tick(us_tick)
    );

    assign fb        = us_tick && (us_cnt == CNT_W'(FRAME_US - 1));
    assign cmd_ready = !pend_full;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        us_cnt_nxt = us_cnt;
        active_nxt = active;
        miss_nxt   = miss_cnt;
        stale_nxt  = stale;
        arm_f_nxt  = arm_f;

        if (us_tick) begin
            us_cnt_nxt = fb ? '0 : us_cnt + CNT_W'(1);
        end

        if (fb) begin
            arm_f_nxt = arm;
            if (pend_full) begin
                active_nxt = sat_cmd(pend);
                miss_nxt   = '0;
                stale_nxt  = 1'b0;
            end else begin
                if (miss_cnt != MISS_W'(TIMEOUT_FRAMES)) begin
                    miss_nxt = miss_cnt + MISS_W'(1);
                end
                if (miss_nxt == MISS_W'(TIMEOUT_FRAMES)) begin
                    active_nxt = '0;
                    stale_nxt  = 1'b1;
                end
            end
        end

        // Compare against the post-update counter and width so the
        // registered line rises exactly one cycle after the frame boundary.
        pulse_nxt = arm_f_nxt && (us_cnt_nxt < CNT_W'(width_us(active_nxt)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt       <= '0;
            pend         <= '0;
            pend_full    <= 1'b0;
            active       <= '0;
            miss_cnt     <= MISS_W'(TIMEOUT_FRAMES);
            stale        <= 1'b1;
            arm_f        <= 1'b0;
            pulse_out    <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            us_cnt       <= us_cnt_nxt;
            active       <= active_nxt;
            miss_cnt     <= miss_nxt;
            stale        <= stale_nxt;
            arm_f        <= arm_f_nxt;
            pulse_out    <= pulse_nxt;
            frame_strobe <= fb;
            // Draining at a boundary and accepting are exclusive, since
            // acceptance needs the buffer empty.
            if (fb && pend_full) begin
                pend_full <= 1'b0;
            end else if (accept) begin
                pend      <= cmd;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rc_pulse_transmitter.sv
module tb_rc_pulse_transmitter;

    localparam int TICKS     = 2;
    localparam int FRAME     = 2500;
    localparam int TMO       = 3;
    localparam int FRAME_CYC = FRAME * TICKS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmd = 8'd0;
    logic       cmd_valid = 1'b0;
    logic       arm = 1'b0;
    logic       cmd_ready;
    logic       pulse_out;
    logic       frame_strobe;
    logic       stale;

    int tests = 0;
    int fails = 0;

    // Frame-level reference model state.
    bit m_pend_full;
    int m_pend;
    int m_active;
    int m_miss;
    bit m_stale;
    bit m_arm_f;
    int tx_q[$];

    always #5 clk = ~clk;

    rc_pulse_transmitter #(
        .TICKS_PER_US  (TICKS),
        .FRAME_US      (FRAME),
        .TIMEOUT_FRAMES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .arm         (arm),
        .pulse_out   (pulse_out),
        .frame_strobe(frame_strobe),
        .stale       (stale)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend_full = 1'b0;
        m_pend      = 0;
        m_active    = 0;
        m_miss      = TMO;
        m_stale     = 1'b1;
        m_arm_f     = 1'b0;
    endtask

    // Runs one frame starting at the negedge where the frame's first cycle
    // is visible. Commands in tx_q are presented from cycle cmd_at onward,
    // arm takes arm_val at cycle arm_at, and the frame may be cut at stop_at.
    task automatic run_frame(input string name, input bit first, input int exp_hi_lit,
                             input int exp_stale_lit, input int cmd_at, input int arm_at,
                             input bit arm_val, input int stop_at);
        int exp_hi;
        int hi_cnt;
        int glitch;
        int stray;
        int state_bad;
        bit accept;
        exp_hi    = m_arm_f ? (1000 + 4 * m_active) * TICKS : 0;
        hi_cnt    = 0;
        glitch    = 0;
        stray     = 0;
        state_bad = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (pulse_out === 1'b1) hi_cnt++;
            if (pulse_out !== (k < exp_hi)) glitch++;
            if (cmd_ready !== !m_pend_full) state_bad++;
            if (stale !== m_stale) state_bad++;
            if (k == 0) begin
                check({name, " strobe_at_start"}, 32'(frame_strobe), 32'(!first));
                check({name, " stale_model"}, 32'(stale), 32'(m_stale));
                if (exp_stale_lit >= 0) check({name, " stale"}, 32'(stale), exp_stale_lit);
            end else if (frame_strobe !== 1'b0) begin
                stray++;
            end
            if (k == stop_at) begin
                check({name, " pulse_shape"}, glitch, 0);
                check({name, " ready_stale_track"}, state_bad, 0);
                return;
            end
            if (k == arm_at) arm = arm_val;
            if (tx_q.size() > 0 && k >= cmd_at) begin
                cmd_valid = 1'b1;
                cmd       = 8'(tx_q[0]);
            end else begin
                cmd_valid = 1'b0;
            end
            accept = cmd_valid && !m_pend_full;
            if (k == FRAME_CYC - 1) begin
                if (m_pend_full) begin
                    m_active    = (m_pend > 250) ? 250 : m_pend;
                    m_pend_full = 1'b0;
                    m_miss      = 0;
                    m_stale     = 1'b0;
                end else begin
                    if (m_miss < TMO) m_miss++;
                    if (m_miss == TMO) begin
                        m_active = 0;
                        m_stale  = 1'b1;
                    end
                end
                m_arm_f = arm;
            end
            if (accept) begin
                m_pend      = tx_q.pop_front();
                m_pend_full = 1'b1;
            end
            @(negedge clk);
        end
        check({name, " width_model"}, hi_cnt, exp_hi);
        if (exp_hi_lit >= 0) check({name, " width"}, hi_cnt, exp_hi_lit);
        check({name, " pulse_shape"}, glitch, 0);
        check({name, " stray_strobe"}, stray, 0);
        check({name, " ready_stale_track"}, state_bad, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        arm       = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset pulse_out", 32'(pulse_out), 0);
        check("reset frame_strobe", 32'(frame_strobe), 0);
        check("reset stale", 32'(stale), 1);
        check("reset cmd_ready", 32'(cmd_ready), 1);
        model_reset();
        rst_n = 1'b1;

        // Unarmed frame after reset; mid-scale command and arm arrive late.
        tx_q.push_back(125);
        run_frame("f0_defaults", 1'b1, 0, 1, $urandom_range(100, 3900), 4000, 1'b1, -1);
        tx_q.push_back(255);
        run_frame("f1_mid", 1'b0, 3000, 0, $urandom_range(0, 4800), -1, 1'b1, -1);
        tx_q.push_back(0);
        run_frame("f2_sat_max", 1'b0, 4000, 0, $urandom_range(0, 4800), -1, 1'b1, -1);
        // Back-to-back commands: the second waits across the boundary.
        tx_q.push_back(50);
        tx_q.push_back(200);
        run_frame("f3_min", 1'b0, 2000, 0, $urandom_range(0, 4800), -1, 1'b1, -1);
        run_frame("f4_bp_first", 1'b0, 2400, 0, 0, -1, 1'b1, -1);
        // No further commands: three frames at 1800 us, then failsafe.
        run_frame("f5_hold1", 1'b0, 3600, 0, 0, -1, 1'b1, -1);
        run_frame("f6_hold2", 1'b0, 3600, 0, 0, -1, 1'b1, -1);
        run_frame("f7_hold3", 1'b0, 3600, 0, 0, -1, 1'b1, -1);
        tx_q.push_back(100);
        run_frame("f8_failsafe", 1'b0, 2000, 1, $urandom_range(0, 4800), -1, 1'b1, -1);
        // Disarm mid-pulse: this pulse completes, next frame is low.
        run_frame("f9_disarm", 1'b0, 2800, 0, 0, 1000, 1'b0, -1);
        // Command accepted in the boundary cycle lands in pend only.
        tx_q.push_back($urandom_range(0, 255));
        run_frame("f10_low", 1'b0, 0, 0, FRAME_CYC - 1, $urandom_range(0, 4000), 1'b1, -1);
        run_frame("f11_fb_accept", 1'b0, 2800, 0, 0, -1, 1'b1, -1);
        run_frame("f12_pre_reset", 1'b0, -1, 0, 0, -1, 1'b1, 500);

        check("mid-pulse before reset", 32'(pulse_out), 1);
        rst_n = 1'b0;
        #1;
        check("async reset pulse_out", 32'(pulse_out), 0);
        check("async reset stale", 32'(stale), 1);
        check("async reset cmd_ready", 32'(cmd_ready), 1);
        check("async reset frame_strobe", 32'(frame_strobe), 0);
        cmd_valid = 1'b0;
        tx_q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        tx_q.push_back($urandom_range(0, 255));
        run_frame("f13_after_reset", 1'b1, 0, 1, $urandom_range(0, 4800), -1, 1'b1, -1);
        run_frame("f14_random", 1'b0, -1, 0, 0, -1, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
